// File: rtl/requant_writeback_arbiter.sv
// requant_writeback_arbiter: per-lane FIFOs drained round-robin into one byte-wide RAM write port.
// Define REQUANT_WB_OVERFLOW_CHECK_EN to get a sticky overflow_err on dropped lane results.
module requant_writeback_arbiter #(
  parameter int SA_N       = 4,
  parameter int MAX_N      = 16,
  parameter int N_BITS     = $clog2(MAX_N),
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              layer_start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [N_BITS:0]                   row_stride,
  input  logic                              flush,
  input  logic [SA_N-1:0]                   in_valid,
  input  logic [SA_N-1:0][N_BITS-1:0]       in_row,
  input  logic [SA_N-1:0][N_BITS-1:0]       in_col,
  input  logic [SA_N-1:0][7:0]              in_data,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [7:0]                        wr_data,
  input  logic                              wr_ready,
  output logic [SA_N-1:0]                   lane_full,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow_err
);
  localparam int PW = (SA_N > 1) ? $clog2(SA_N) : 1;
  localparam int DW = $clog2(FIFO_DEPTH);
  localparam int CW = DW + 1;
  localparam int EW = 2 * N_BITS + 8;
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [N_BITS:0]         stride_q;
  logic [EW-1:0]           mem [SA_N][FIFO_DEPTH];
  logic [DW-1:0]           wp [SA_N];
  logic [DW-1:0]           rp [SA_N];
  logic [CW-1:0]           cnt [SA_N];
  logic [SA_N-1:0]         ne, push, acc, pop;
  logic [PW-1:0]           rr_ptr, win;
  logic [PW:0]             s;
  logic                    found, load, grant, drain_ok;
  logic [EW-1:0]           head;
  logic [N_BITS-1:0]       h_row, h_col;
  logic [2*N_BITS:0]       prod;
  logic [ADDR_WIDTH-1:0]   addr_next;

  assign busy = state != IDLE;
  assign done = state == DONE;
  assign push = in_valid & {SA_N{state == ACTIVE || state == DRAIN}};

  always_comb begin
    ne = '0;
    lane_full = '0;
    for (int i = 0; i < SA_N; i++) begin
      ne[i] = cnt[i] != '0;
      lane_full[i] = cnt[i] == CW'(FIFO_DEPTH);
    end
  end

  // Scan lanes starting at rr_ptr; first non-empty lane wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    s = '0;
    for (int k = 0; k < SA_N; k++) begin
      s = {1'b0, rr_ptr} + (PW+1)'(k);
      s = (s >= (PW+1)'(SA_N)) ? s - (PW+1)'(SA_N) : s;
      if (!found && ne[s[PW-1:0]]) begin
        found = 1'b1;
        win = s[PW-1:0];
      end
    end
  end

  assign load     = !wr_en || wr_ready;
  assign grant    = found && load;
  assign pop      = {{(SA_N-1){1'b0}}, grant} << win;
  assign acc      = push & (~lane_full | pop);
  assign drain_ok = ~|ne && load && ~|push;

  assign head           = mem[win][rp[win]];
  assign {h_row, h_col} = head[EW-1:8];
  assign prod           = h_row * stride_q;
  assign addr_next      = base_q + ADDR_WIDTH'(prod) + ADDR_WIDTH'(h_col);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base_q <= '0;
      stride_q <= '0;
      rr_ptr <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < SA_N; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SA_N; i++) begin
        if (acc[i]) begin
          mem[i][wp[i]] <= {in_row[i], in_col[i], in_data[i]};
          wp[i] <= wp[i] + DW'(1);
        end
        if (pop[i]) rp[i] <= rp[i] + DW'(1);
        cnt[i] <= cnt[i] + CW'(acc[i]) - CW'(pop[i]);
      end
      if (grant) begin
        wr_en <= 1'b1;
        wr_addr <= addr_next;
        wr_data <= head[7:0];
        rr_ptr <= (win == PW'(SA_N - 1)) ? '0 : win + PW'(1);
      end else if (wr_ready) begin
        wr_en <= 1'b0;
      end
      case (state)
        IDLE: if (layer_start) begin
          state <= ACTIVE;
          base_q <= base_addr;
          stride_q <= row_stride;
        end
        ACTIVE: state <= flush ? DRAIN : ACTIVE;
        DRAIN: state <= drain_ok ? DONE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REQUANT_WB_OVERFLOW_CHECK_EN
  logic [SA_N-1:0] drop;
  logic            ov;
  assign drop = push & lane_full & ~pop;
  assign overflow_err = ov;
  always_ff @(posedge clk) begin
    if (reset) ov <= 1'b0;
    else if (state == IDLE && layer_start) ov <= 1'b0;
    else if (|drop) ov <= 1'b1;
  end
`else
  assign overflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_requant_writeback_arbiter.sv
// tb_requant_writeback_arbiter: directed bench with a write scoreboard for requant_writeback_arbiter.
module tb_requant_writeback_arbiter;
  localparam int SA_N = 4, N_BITS = 4, AW = 12;
`ifdef REQUANT_WB_OVERFLOW_CHECK_EN
  localparam logic OV_EXP = 1'b1;
`else
  localparam logic OV_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, layer_start, flush, wr_ready;
  logic [AW-1:0] base_addr;
  logic [N_BITS:0] row_stride;
  logic [SA_N-1:0] in_valid;
  logic [SA_N-1:0][N_BITS-1:0] in_row, in_col;
  logic [SA_N-1:0][7:0] in_data;
  logic wr_en, busy, done, overflow_err;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [SA_N-1:0] lane_full;

  int tests = 0, fails = 0;
  logic [19:0] sb[$];

  requant_writeback_arbiter dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .base_addr(base_addr),
    .row_stride(row_stride), .flush(flush), .in_valid(in_valid), .in_row(in_row),
    .in_col(in_col), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .lane_full(lane_full), .busy(busy),
    .done(done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ew(input int base, input int stride, input int r, input int c, input int d);
    logic [31:0] a, dd;
    a = base + r * stride + c;
    dd = d;
    return {a[11:0], dd[7:0]};
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && wr_en === 1'b1 && wr_ready === 1'b1) begin
      chk("write_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("write", {wr_addr, wr_data}, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input int r, input int c, input int d);
    in_valid[i] = 1'b1;
    in_row[i] = N_BITS'(r);
    in_col[i] = N_BITS'(c);
    in_data[i] = 8'(d);
  endtask

  task automatic start_layer(input int base, input int stride);
    base_addr = AW'(base);
    row_stride = 5'(stride);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !wr_en) break;
      tick();
    end
    chk("drain_left", 32'(sb.size()), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 1);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_lane_full"}, 32'(lane_full), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_overflow"}, 32'(overflow_err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nw, nd, last_w, done_i;
    reset = 1'b1; layer_start = 1'b0; flush = 1'b0; wr_ready = 1'b1;
    base_addr = '0; row_stride = '0; in_valid = '0; in_row = '0; in_col = '0; in_data = '0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Inputs while idle are discarded
    lane(0, 1, 1, 8'h11);
    tick();
    in_valid = '0;
    repeat (4) tick();
    chk("idle_no_write", 32'(wr_en), 0);
    chk("idle_lane_full", 32'(lane_full), 0);

    // Contention: rr_ptr starts at 0, four consecutive writes lanes 0..3
    start_layer(0, 16);
    chk("busy_active", 32'(busy), 1);
    for (int i = 0; i < SA_N; i++) begin
      lane(i, i, i, 8'h10 + i);
      sb.push_back(ew(0, 16, i, i, 8'h10 + i));
    end
    tick();
    in_valid = '0;
    chk("burst_t1", 32'(wr_en), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("burst_wr_en", 32'(wr_en), 1);
      tick();
    end
    chk("burst_end", 32'(wr_en), 0);
    for (int i = 0; i < SA_N; i++) begin
      lane(i, i, 15 - i, 8'h50 + i);
      sb.push_back(ew(0, 16, i, 15 - i, 8'h50 + i));
    end
    tick();
    in_valid = '0;
    wait_drain();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done();

    // Single result latency and address
    start_layer(12'h100, 8);
    lane(2, 3, 5, -7);
    sb.push_back(ew(12'h100, 8, 3, 5, -7));
    tick();
    in_valid = '0;
    chk("lat_t1", 32'(wr_en), 0);
    tick();
    chk("lat_t2", 32'(wr_en), 1);
    chk("lat_addr", 32'(wr_addr), 32'h11D);
    chk("lat_data", 32'(wr_data), 32'hF9);
    wait_drain();

    // Backpressure with rr_ptr=3: lane 3 first, outputs held for 5 cycles
    wr_ready = 1'b0;
    for (int i = 0; i < SA_N; i++) lane(i, i, 1, 8'h20 + i);
    tick();
    for (int i = 0; i < SA_N; i++) lane(i, i, 2, 8'h30 + i);
    tick();
    in_valid = '0;
    sb.push_back(ew(12'h100, 8, 3, 1, 8'h23));
    for (int i = 0; i < 3; i++) sb.push_back(ew(12'h100, 8, i, 1, 8'h20 + i));
    sb.push_back(ew(12'h100, 8, 3, 2, 8'h33));
    for (int i = 0; i < 3; i++) sb.push_back(ew(12'h100, 8, i, 2, 8'h30 + i));
    chk("bp_wr_en", 32'(wr_en), 1);
    chk("bp_held", {wr_addr, wr_data}, ew(12'h100, 8, 3, 1, 8'h23));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_wr_en", 32'(wr_en), 1);
      chk("bp_held", {wr_addr, wr_data}, ew(12'h100, 8, 3, 1, 8'h23));
    end
    chk("bp_lane_full", 32'(lane_full), 0);
    wr_ready = 1'b1;
    wait_drain();

    // Overflow: output register occupied by lane 1, lane 0 pushes 5 and 6 dropped
    wr_ready = 1'b0;
    lane(1, 2, 3, 8'h61);
    sb.push_back(ew(12'h100, 8, 2, 3, 8'h61));
    tick();
    in_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      lane(0, 0, k, 8'h40 + k);
      if (k <= 4) sb.push_back(ew(12'h100, 8, 0, k, 8'h40 + k));
      tick();
    end
    in_valid = '0;
    chk("ovf_lane_full", 32'(lane_full), 32'h1);
    chk("ovf_err", 32'(overflow_err), 32'(OV_EXP));
    chk("ovf_held", {wr_addr, wr_data}, ew(12'h100, 8, 2, 3, 8'h61));
    wr_ready = 1'b1;
    wait_drain();
    chk("ovf_lane_free", 32'(lane_full), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done();
    chk("ovf_sticky", 32'(overflow_err), 32'(OV_EXP));

    // Drain/done with 3 pending entries; rr_ptr=1 so order is lanes 1,2,0
    start_layer(12'h200, 4);
    chk("ovf_cleared", 32'(overflow_err), 0);
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) lane(i, i, i, 8'h70 + i);
    sb.push_back(ew(12'h200, 4, 1, 1, 8'h71));
    sb.push_back(ew(12'h200, 4, 2, 2, 8'h72));
    sb.push_back(ew(12'h200, 4, 0, 0, 8'h70));
    tick();
    in_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("drain_busy", 32'(busy), 1);
    chk("drain_no_done", 32'(done), 0);
    wr_ready = 1'b1;
    nw = 0; nd = 0; last_w = -1; done_i = -1;
    for (int i = 0; i < 12; i++) begin
      if (wr_en && wr_ready) begin nw++; last_w = i; end
      if (done) begin nd++; done_i = i; end
      tick();
    end
    chk("drain_writes", 32'(nw), 3);
    chk("drain_done_count", 32'(nd), 1);
    chk("drain_done_gap", 32'(done_i - last_w), 1);
    chk("drain_idle", 32'(busy), 0);

    // Address wrap modulo 2^12
    start_layer(12'hFF8, 8);
    lane(3, 1, 0, 8'h55);
    sb.push_back(ew(12'hFF8, 8, 1, 0, 8'h55));
    tick();
    in_valid = '0;
    tick();
    chk("wrap_wr_en", 32'(wr_en), 1);
    chk("wrap_addr", 32'(wr_addr), 0);
    wait_drain();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done();

    // Reset in DRAIN: everything cleared, no done, no writes
    start_layer(12'h300, 1);
    wr_ready = 1'b0;
    for (int i = 0; i < SA_N; i++) lane(i, i, i, 8'h80 + i);
    tick();
    in_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rst_pre_busy", 32'(busy), 1);
    chk("rst_pre_wr_en", 32'(wr_en), 1);
    reset = 1'b1;
    tick();
    chk_zero("midreset");
    reset = 1'b0;
    wr_ready = 1'b1;
    nd = 0;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) nd++;
      if (wr_en) nw++;
      tick();
    end
    chk("rst_no_done", 32'(nd), 0);
    chk("rst_no_write", 32'(nw), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/requant_writeback_arbiter.md
# requant_writeback_arbiter

Sequences requantized int8 results from the SA_N requantize/activate lanes into the single-byte write port of the output activation RAM. Each lane feeds a small FIFO, and the FIFOs are drained by a round-robin arbiter. The block computes the RAM address from the lane's (row, col) tag and per-layer base/stride. It also runs a per-layer start/drain/done handshake, so the layer sequencer knows when every result of a layer has been written back.

## Interface
- SA_N, 4, number of requantize lanes
- MAX_N, 16, max output rows/cols per tile
- N_BITS, $clog2(MAX_N), row/col tag width
- FIFO_DEPTH, 4, entries per lane FIFO (power of two, ≥2)
- ADDR_WIDTH, 12, output RAM byte-address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- layer_start  in  1  pulse; latches base_addr/row_stride, IDLE→ACTIVE
- base_addr  in  ADDR_WIDTH  layer output base byte address
- row_stride  in  N_BITS+1  bytes per output row
- flush  in  1  pulse; no more lane data this layer, begin drain
- in_valid  in  [SA_N]×1  lane result valid (lanes cannot stall)
- in_row  in  [SA_N]×N_BITS  lane result row
- in_col  in  [SA_N]×N_BITS  lane result col
- in_data  in  [SA_N]×int8_t  lane result
- wr_en  out  1  RAM write request
- wr_addr  out  ADDR_WIDTH  RAM byte address
- wr_data  out  int8_t  RAM write data
- wr_ready  in  1  RAM accepts write this cycle
- lane_full  out  [SA_N]×1  lane FIFO full
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, layer fully written
- overflow_err  out  1  sticky lost-result flag (see Configuration)

## Operation
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE→ACTIVE on layer_start.
  - ACTIVE→DRAIN on flush.
  - DRAIN→DONE when all FIFOs are empty and the output register is empty, or is being accepted that cycle.
  - DONE→IDLE unconditionally after one cycle.
- layer_start is honored only in IDLE. Elsewhere it is ignored.
- flush is honored only in ACTIVE. Elsewhere it is ignored.
- Lane inputs are pushed only in ACTIVE and DRAIN. In IDLE and DONE they are discarded silently.
- Each lane FIFO stores {row, col, data}.
  - If a push hits a full FIFO with a pop in the same cycle, the push is accepted.
  - If a push hits a full FIFO with no pop, the entry is dropped.
- Arbiter:
  - Round-robin among non-empty FIFOs, starting at rr_ptr (reset 0).
  - The winner pops into the output register when the register is empty or is being accepted this cycle.
  - rr_ptr ← winner+1 mod SA_N.
  - A lane starved by RR waits at most SA_N−1 grants.
- Address: wr_addr = (base_addr + row×row_stride + col) truncated to ADDR_WIDTH. The computation is unsigned and wraps modulo 2^ADDR_WIDTH.
- Output register: wr_en/wr_addr/wr_data hold stable while wr_en=1 and wr_ready=0.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0.
  - lane_full=0, busy=0, done=0, overflow_err=0.
  - FIFOs empty, rr_ptr=0, state IDLE.
- Latency: lane input at cycle t enters the FIFO at edge t. With no contention, wr_en asserts in cycle t+2.
- Throughput: one write per cycle while wr_ready=1.
- done is asserted in the cycle the FSM is in DONE. The earliest is 1 cycle after the last write handshake.
- Reset mid-operation clears FIFOs, the output register and the FSM within one edge. Pending writes are lost, and no done pulse is issued.
- lane_full is combinational from the FIFO count.

## Configuration
- REQUANT_WB_OVERFLOW_CHECK_EN:
  - Defined: overflow_err sets on any dropped push. It is sticky, and clears on reset or an accepted layer_start.
  - Undefined: overflow_err is tied 0 and the detection logic is removed. Drops still occur silently.

## Test plan
- Single result: layer_start (base=0x100, stride=8), lane 2 in (row 3, col 5, data −7) at cycle 10 → wr_en at cycle 12, addr 0x11D, data 0xF9.
- Contention: all 4 lanes valid in one cycle, wr_ready=1 → writes on 4 consecutive cycles in order lanes 0,1,2,3. A second burst is served starting from lane 0 (rr_ptr wrapped).
- Backpressure: wr_ready=0 for 5 cycles during a burst → outputs held stable. Nothing is lost with FIFO_DEPTH=4 and ≤4 pushes per lane. Resuming wr_ready=1 drains all entries.
- Overflow: lane 0 valid for 6 cycles with wr_ready=0 → entries 5–6 dropped and lane_full=1. With the macro defined, overflow_err=1 until the next layer_start.
- Drain/done: flush with 3 entries pending → exactly 3 writes, then a single-cycle done, then busy=0. Inputs arriving in IDLE produce no writes.
- Wrap/reset: base=0xFF8, row 1, col 0, stride 8 → addr 0x000. Reset asserted in DRAIN → all outputs 0 next cycle and no done.
